// File: rtl/sdadc_pkg.sv
// sdadc_pkg
// Shared definitions for the sigma-delta ADC decimation chain. The CIC
// decimator and the half-band stages use this package.
//   CIC_ORDER        : number of integrator and comb stages
//   CIC_DECIM        : CIC decimation factor (power of two)
//   CIC_OUTPUT_WIDTH : CIC output width, equal to the half-band input width
//   CIC_ACC_WIDTH    : integrator/comb register width, 2 + ORDER*log2(DECIM)
//   cic_state_t      : CIC control FSM state encoding
package sdadc_pkg;

    localparam int CIC_ORDER        = 5;
    localparam int CIC_DECIM        = 64;
    localparam int CIC_OUTPUT_WIDTH = 50;

    // Register growth of a CIC fed by a 2-bit signed (+/-1) sample.
    function automatic int cic_acc_width(input int order, input int decim);
        return 32'sd2 + order * $clog2(decim);
    endfunction

    localparam int CIC_ACC_WIDTH = cic_acc_width(CIC_ORDER, CIC_DECIM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMB   = 2'd1,
        ST_OUTPUT = 2'd2
    } cic_state_t;

endpackage

// File: rtl/cic_integrator.sv
// cic_integrator
// One wrapping two's-complement accumulator with enable.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears the accumulator
//   en  : accumulate enable (the input-sample strobe)
//   din : value added on enabled cycles
//   sum : accumulator plus din, i.e. the value the accumulator takes on the
//         next enabled edge; the next stage chains off this so that every
//         stage sees the current sample in the same cycle
module cic_integrator #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] sum
);

    logic signed [WIDTH-1:0] acc_r;

    // Modulo-2^WIDTH add; overflow is harmless because the combs undo it.
    assign sum = acc_r + din;

    // Accumulator register: updates only on sample strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= sum;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator
// ORDER-stage CIC decimator for a 1-bit sigma-delta stream. The integrators
// run at the input strobe rate. Each decimated sample is captured and then
// passed through the comb section one stage per clock. The comb section is a
// single subtractor shared across the stages.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_bit carries a new modulator sample
//   in_bit    : modulator bit, 1 -> +1, 0 -> -1
//   out_valid : one-cycle pulse, out_data holds a new decimated sample
//   out_data  : decimated sample, sign-extended, held between pulses
module cic_decimator
    import sdadc_pkg::*;
#(
    parameter int ORDER        = CIC_ORDER,
    parameter int DECIM        = CIC_DECIM,
    parameter int OUTPUT_WIDTH = CIC_OUTPUT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_bit,
    output logic                           out_valid,
    output logic signed [OUTPUT_WIDTH-1:0] out_data
);

    localparam int ACC_WIDTH = cic_acc_width(ORDER, DECIM);
    localparam int CNT_W     = $clog2(DECIM);
    localparam int IDX_W     = $clog2(ORDER + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ORDER - 1);

    // The comb pass must finish before the next capture arrives.
    if ((DECIM < ORDER + 2) || ((DECIM & (DECIM - 1)) != 0)) begin : g_bad_decim
        $error("cic_decimator: DECIM must be a power of two and >= ORDER+2");
    end
    if (OUTPUT_WIDTH < ACC_WIDTH) begin : g_bad_width
        $error("cic_decimator: OUTPUT_WIDTH must be >= ACC_WIDTH");
    end

    logic signed [1:0]           sample_s;
    logic signed [ACC_WIDTH-1:0] stage_in_s  [ORDER];
    logic signed [ACC_WIDTH-1:0] stage_sum_s [ORDER];
    logic [CNT_W-1:0]            cnt_r;
    logic                        capture_s;

    cic_state_t                  state_r;
    logic [IDX_W-1:0]            idx_r;
    logic signed [ACC_WIDTH-1:0] x_r;
    logic signed [ACC_WIDTH-1:0] d_r [ORDER];

    assign sample_s      = in_bit ? 2'sb01 : 2'sb11;
    assign stage_in_s[0] = ACC_WIDTH'(sample_s);

    for (genvar k = 0; k < ORDER; k++) begin : g_int
        if (k > 0) begin : g_chain
            assign stage_in_s[k] = stage_sum_s[k-1];
        end
        cic_integrator #(
            .WIDTH (ACC_WIDTH)
        ) u_int (
            .clk (clk),
            .rst (rst),
            .en  (in_valid),
            .din (stage_in_s[k]),
            .sum (stage_sum_s[k])
        );
    end

    // Capture takes the last integrator value including the current sample.
    assign capture_s = in_valid && (cnt_r == CNT_LAST);

    // Decimation counter: advances on every strobe, in any FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (in_valid) begin
            cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Control FSM with the time-multiplexed comb and the output registers.
    // x_r holds the captured sample and then each intermediate comb result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            x_r       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < ORDER; k++) begin
                d_r[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (capture_s) begin
                        x_r     <= stage_sum_s[ORDER-1];
                        idx_r   <= '0;
                        state_r <= ST_COMB;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMB: begin
                    x_r        <= x_r - d_r[idx_r];
                    d_r[idx_r] <= x_r;
                    if (idx_r == IDX_LAST) begin
                        idx_r   <= '0;
                        state_r <= ST_OUTPUT;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= ST_COMB;
                    end
                end
                ST_OUTPUT: begin
                    out_data  <= OUTPUT_WIDTH'(x_r);
                    out_valid <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    idx_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator
// Self-checking bench for cic_decimator at default parameters. The reference
// model treats the CIC as an FIR filter. It convolves the +/-1 input history
// with the CIC impulse response, which is a 64-tap boxcar convolved with
// itself 5 times. The output appears ORDER+1 cycles after every 64th accepted
// sample.
module tb_cic_decimator;

    localparam int ORDER = 5;
    localparam int DECIM = 64;
    localparam int OW    = 50;
    localparam int HLEN  = ORDER * (DECIM - 1) + 1;
    localparam int LAT   = ORDER + 1;
    localparam logic signed [OW-1:0] POS_FS = 50'sd1073741824;
    localparam logic signed [OW-1:0] NEG_FS = -50'sd1073741824;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_bit = 1'b0;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;

    cic_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint               due;
        logic signed [OW-1:0] val;
    } pend_t;

    int     n_cmp  = 0;
    int     n_fail = 0;
    longint h [HLEN];
    int     hist [$];
    pend_t  pend [$];
    int     acc_cnt = 0;
    longint cyc = 0;
    logic signed [OW-1:0] last_d = '0;

    logic                 obs_v, exp_v, cap;
    logic signed [OW-1:0] obs_d, exp_d;

    // CIC impulse response: a boxcar of DECIM ones convolved ORDER times.
    task automatic build_h();
        longint tmp [HLEN];
        int     len;
        for (int j = 0; j < HLEN; j++) h[j] = (j < DECIM) ? 64'sd1 : 64'sd0;
        len = DECIM;
        for (int s = 1; s < ORDER; s++) begin
            for (int j = 0; j < HLEN; j++) tmp[j] = 64'sd0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < DECIM; j++) tmp[i+j] += h[i];
            len += DECIM - 1;
            for (int j = 0; j < HLEN; j++) h[j] = tmp[j];
        end
    endtask

    // Drive one clock of stimulus, advance the model, then sample the outputs.
    task automatic step(input logic v, input logic b, input logic r);
        pend_t  p;
        longint y;
        in_valid = v;
        in_bit   = b;
        rst      = r;
        @(posedge clk);
        cyc++;
        cap = 1'b0;
        if (r) begin
            hist.delete();
            pend.delete();
            acc_cnt = 0;
            last_d  = '0;
        end else if (v) begin
            hist.push_front(b ? 1 : -1);
            if (hist.size() > HLEN) void'(hist.pop_back());
            acc_cnt++;
            if (acc_cnt % DECIM == 0) begin
                y = 0;
                for (int j = 0; j < hist.size(); j++) y += h[j] * longint'(hist[j]);
                p.due = cyc + LAT;
                p.val = OW'(int'(y));
                pend.push_back(p);
                cap = 1'b1;
            end
        end
        #1;
        obs_v = out_valid;
        obs_d = out_data;
        exp_v = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_v  = 1'b1;
            last_d = pend[0].val;
            void'(pend.pop_front());
        end
        exp_d = last_d;
    endtask

    task automatic test_reset();
        repeat (2) step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs_v !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", obs_v); end
        n_cmp++;
        if (obs_d !== '0) begin n_fail++; $display("FAIL reset_data got %0d want 0", obs_d); end
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            n_cmp++;
            if (obs_v !== exp_v || obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL reset_run cyc=%0d got %b/%0d want %b/%0d", cyc, obs_v, obs_d, exp_v, exp_d);
            end
        end
        // Reset together with a strobe: the strobed sample is dropped.
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (obs_v !== 1'b0 || obs_d !== '0) begin
            n_fail++;
            $display("FAIL reset_with_strobe got %b/%0d want 0/0", obs_v, obs_d);
        end
    endtask

    // Constant input of +1 or -1: checked against the model and the full-scale constant.
    task automatic test_const(input logic b, input int n_out, input logic signed [OW-1:0] fs);
        int     pulses = 0;
        longint last_pulse = 0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DECIM * n_out; i++) begin
            step(1'b1, b, 1'b0);
            n_cmp++;
            if (obs_v !== exp_v || obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL const%0b_model cyc=%0d got %b/%0d want %b/%0d", b, cyc, obs_v, obs_d, exp_v, exp_d);
            end
            if (obs_v === 1'b1) begin
                pulses++;
                if (pulses >= 5) begin
                    n_cmp++;
                    if (obs_d !== fs) begin n_fail++; $display("FAIL const%0b_level got %0d want %0d", b, obs_d, fs); end
                end
                if (pulses > 1) begin
                    n_cmp++;
                    if (cyc - last_pulse != DECIM) begin
                        n_fail++;
                        $display("FAIL const%0b_spacing got %0d want %0d", b, cyc - last_pulse, DECIM);
                    end
                end
                last_pulse = cyc;
            end
        end
        n_cmp++;
        if (pulses < n_out - 1) begin n_fail++; $display("FAIL const%0b_count got %0d want >= %0d", b, pulses, n_out - 1); end
    endtask

    task automatic test_alternating();
        int pulses = 0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DECIM * 8; i++) begin
            step(1'b1, (i % 2 == 0), 1'b0);
            n_cmp++;
            if (obs_v !== exp_v || obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL alt_model cyc=%0d got %b/%0d want %b/%0d", cyc, obs_v, obs_d, exp_v, exp_d);
            end
            if (obs_v === 1'b1) begin
                pulses++;
                if (pulses >= 5) begin
                    n_cmp++;
                    if (obs_d !== '0) begin n_fail++; $display("FAIL alt_level got %0d want 0", obs_d); end
                end
            end
        end
    endtask

    task automatic test_sparse();
        longint           cap_cyc = -1;
        logic [OW-33:0]   hi;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DECIM * 3 * 8; i++) begin
            step((i % 3 == 0), 1'($urandom), 1'b0);
            if (cap) cap_cyc = cyc;
            n_cmp++;
            if (obs_v !== exp_v || obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL sparse_model cyc=%0d got %b/%0d want %b/%0d", cyc, obs_v, obs_d, exp_v, exp_d);
            end
            if (obs_v === 1'b1) begin
                n_cmp++;
                if (cyc - cap_cyc != LAT) begin
                    n_fail++;
                    $display("FAIL sparse_latency got %0d want %0d", cyc - cap_cyc, LAT);
                end
                hi = obs_d[OW-1:32];
                n_cmp++;
                if (hi !== {(OW-32){obs_d[31]}}) begin
                    n_fail++;
                    $display("FAIL sparse_signext got %h want all %b", hi, obs_d[31]);
                end
            end
        end
    endtask

    task automatic test_random();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 299) == 0));
            n_cmp++;
            if (obs_v !== exp_v || obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got %b/%0d want %b/%0d", cyc, obs_v, obs_d, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid_comb();
        int     pulses = 0;
        longint last_pulse = 0;
        step(1'b0, 1'b0, 1'b1);
        // Five outputs, then the 6th capture; reset lands two edges into COMB.
        for (int i = 0; i < DECIM * 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs_v !== exp_v || obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL midrst_pre cyc=%0d got %b/%0d want %b/%0d", cyc, obs_v, obs_d, exp_v, exp_d);
            end
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs_v !== 1'b0 || obs_d !== '0) begin
                n_fail++;
                $display("FAIL midrst_quiet cyc=%0d got %b/%0d want 0/0", cyc, obs_v, obs_d);
            end
        end
        for (int i = 0; i < DECIM * 7; i++) begin
            step(1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs_v !== exp_v || obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL midrst_post cyc=%0d got %b/%0d want %b/%0d", cyc, obs_v, obs_d, exp_v, exp_d);
            end
            if (obs_v === 1'b1) begin
                pulses++;
                if (pulses >= 5) begin
                    n_cmp++;
                    if (obs_d !== POS_FS) begin n_fail++; $display("FAIL midrst_level got %0d want %0d", obs_d, POS_FS); end
                end
                if (pulses > 1) begin
                    n_cmp++;
                    if (cyc - last_pulse != DECIM) begin
                        n_fail++;
                        $display("FAIL midrst_spacing got %0d want %0d", cyc - last_pulse, DECIM);
                    end
                end
                last_pulse = cyc;
            end
        end
    endtask

    initial begin
        build_h();
        test_reset();
        test_const(1'b1, 40, POS_FS);   // long run: integrators wrap many times
        test_const(1'b0, 8, NEG_FS);
        test_alternating();
        test_sparse();
        test_random();
        test_reset_mid_comb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 The block SHALL have parameter ORDER, default 5, the number of integrator and comb stages.
REQ-002 The block SHALL have parameter DECIM, default 64, the decimation factor; it SHALL be a power of two with DECIM >= ORDER+2, enforced by an elaboration-time check.
REQ-003 The block SHALL have parameter OUTPUT_WIDTH, default 50, the output width matching the downstream half-band input; it SHALL be >= ACC_WIDTH, enforced by an elaboration-time check.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: strobe marking in_bit as a new modulator sample.
REQ-007 The block SHALL have port in_bit, input, 1 bit: sigma-delta modulator output bit.
REQ-008 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new decimated sample.
REQ-009 The block SHALL have port out_data, output, signed OUTPUT_WIDTH bits: the decimated sample.

Function
REQ-010 The block SHALL define ACC_WIDTH = 2 + ORDER*log2(DECIM), which is 32 at the defaults; all integrator and comb arithmetic SHALL be ACC_WIDTH-bit two's complement, wrapping modulo 2^ACC_WIDTH with no saturation.
REQ-011 The block SHALL map in_bit to a 2-bit signed value: 1 maps to +1, 0 maps to -1.
REQ-012 The ORDER cascaded integrators SHALL update only on cycles with in_valid=1, with stage k accumulating the new output of stage k-1 in the same cycle; they SHALL hold when in_valid=0.
REQ-013 A decimation counter SHALL count 0..DECIM-1 on each in_valid; when in_valid=1 and the counter equals DECIM-1, the last integrator value including the current sample SHALL be captured, and the counter SHALL return to 0.
REQ-014 Control SHALL be an FSM with states IDLE, COMB and OUTPUT; a capture SHALL move IDLE to COMB with the stage index at 0.
REQ-015 In COMB, one comb stage SHALL be evaluated per cycle: y = x - d[k], then d[k] <= x, for k = 0..ORDER-1; after stage ORDER-1 the FSM SHALL go to OUTPUT.
REQ-016 OUTPUT SHALL register out_data as the sign-extension of the final comb result to OUTPUT_WIDTH, pulse out_valid for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: out_valid SHALL rise exactly ORDER+1 cycles after the capturing clock edge.
REQ-018 Integrators and the decimation counter SHALL keep running during COMB and OUTPUT; an in_valid arriving in those states SHALL never be dropped.
REQ-019 out_data SHALL hold its value between out_valid pulses; out_valid SHALL be 0 in every cycle except the OUTPUT cycle.
REQ-020 DC gain SHALL be DECIM^ORDER, which is 2^30 at the defaults, with no output scaling.

Reset
REQ-021 When rst=1 at a clock edge, all integrators, comb delays, the decimation counter and the stage index SHALL clear to 0, the FSM SHALL enter IDLE, out_valid SHALL be 0, and out_data SHALL be 0.
REQ-022 A reset asserted during COMB or OUTPUT SHALL discard the in-flight sample, so that no out_valid pulse follows the reset.
REQ-023 rst SHALL take priority over a simultaneous in_valid, and that sample SHALL be discarded.

Structure
REQ-024 ORDER, DECIM, OUTPUT_WIDTH defaults, ACC_WIDTH and the FSM state encoding SHALL be defined in the shared package sdadc_pkg, which the half-band stages also use.
REQ-025 One sub-module, cic_integrator (a single wrapping accumulator with enable), SHALL be instantiated ORDER times; the combs SHALL be time-multiplexed inside cic_decimator.

Verification
REQ-026 Scenario (constant ones): in_valid=1 every cycle, in_bit=1 from reset -> from the 5th out_valid onward, out_data = +1073741824 (2^30), and out_valid pulses are spaced exactly 64 cycles apart.
REQ-027 Scenario (constant zeros): in_bit=0 continuous -> from the 5th output onward, out_data = -1073741824.
REQ-028 Scenario (alternating bits): in_bit alternating 1,0 -> from the 5th output onward, out_data = 0.
REQ-029 Scenario (latency and sparse strobes): in_valid every third cycle -> out_valid exactly 6 cycles after every 64th accepted sample edge; integrators advance only on strobes; sign-extension bits [49:32] equal bit 31.
REQ-030 Scenario (reset mid-operation): rst asserted 2 cycles into COMB -> no out_valid pulse; all outputs 0; after release, the constant-ones stimulus reproduces the REQ-026 sequence exactly.
REQ-031 Scenario (wrap-around): run more than 2^26 constant-ones samples -> integrators wrap, and out_data remains +2^30 with no glitch.
